// File: rtl/audio_nios_pkg.sv
// Shared definitions for the audio NIOS sample reader.
//   rd_state_e     : reader FSM state encoding (IDLE, RUN, DRAIN)
//   FIFO_DEPTH_DEF : default depth of the sample output buffer
package audio_nios_pkg;

  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/audio_nios_sample_fifo.sv
// Synchronous show-ahead FIFO used as the sample output buffer.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   flush        : empties the buffer; takes priority over write and read
//   wr_en/wr_data: push one word (ignored when full)
//   rd_en        : pop the head word (ignored when empty)
//   rd_data      : current head word, valid whenever empty is low
//   empty, count : occupancy status
module audio_nios_sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, wr_ok, rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_L);
  assign wr_ok   = wr_en && !full && !flush;
  assign rd_ok   = rd_en && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Storage is data only and is never reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_nios_sample_reader.sv
// Reads a block of words from on-chip memory over an Avalon-MM master port
// (fixed 1-cycle read latency, no waitrequest) and streams them out as
// audio samples through a small show-ahead buffer with valid/ready flow control.
//   start/stop          : one-cycle control pulses (stop wins when both high)
//   base_addr/length    : block to read, loop_en restarts at base_addr forever
//   busy/done           : busy in RUN/DRAIN, done pulses at non-looping completion
//   avm_*               : memory master command and read data
//   smp_data/valid/ready: sample stream to the codec path
module audio_nios_sample_reader
  import audio_nios_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  rd_state_e         state, state_nxt;
  logic              done_q, done_nxt;
  logic [ADDR_W-1:0] ptr, base_q, len_q, issue_left, accept_left;
  logic              loop_q;
  logic              rd_vld_p1;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              fifo_empty, fifo_wr, fifo_flush;
  logic              start_ok, rd_issue, xfer, last_accept;

  assign start_ok  = start && !stop;
  assign xfer      = smp_valid && smp_ready;
  // Words already buffered plus the one still in the memory pipeline must
  // leave room, so the buffer can never overflow.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_vld_p1};
  assign rd_issue  = (state == RUN) && !stop && (issue_left != '0) &&
                     (occupancy < DEPTH_L);
  assign last_accept = xfer && !loop_q && (accept_left == ADDR_W'(1));

  // A stop flushes on the same edge so smp_valid is low throughout DRAIN;
  // any word returned by memory while stopping or draining is dropped.
  assign fifo_flush = ((state == RUN) && stop) || (state == DRAIN);
  assign fifo_wr    = rd_vld_p1 && (state == RUN) && !stop;

  assign avm_address    = ptr;
  assign avm_chipselect = rd_issue;
  assign avm_read       = rd_issue;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = 1'b1;
  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign smp_valid      = !fifo_empty;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (length == '0) done_nxt  = 1'b1;
          else              state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (last_accept) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  // Address/count bookkeeping; the last issued word either reloads the
  // block (looping) or exhausts issue_left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      base_q      <= '0;
      len_q       <= '0;
      issue_left  <= '0;
      accept_left <= '0;
      loop_q      <= 1'b0;
    end else if ((state == IDLE) && start_ok && (length != '0)) begin
      ptr         <= base_addr;
      base_q      <= base_addr;
      len_q       <= length;
      issue_left  <= length;
      accept_left <= length;
      loop_q      <= loop_en;
    end else begin
      if (rd_issue) begin
        if ((issue_left == ADDR_W'(1)) && loop_q) begin
          ptr        <= base_q;
          issue_left <= len_q;
        end else begin
          ptr        <= ptr + ADDR_W'(1);
          issue_left <= issue_left - ADDR_W'(1);
        end
      end
      if (xfer && (state == RUN) && !loop_q) accept_left <= accept_left - ADDR_W'(1);
    end
  end

  // ---- p0 -> p1: read issued, data returns from memory next cycle ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld_p1 <= 1'b0;
    else          rd_vld_p1 <= rd_issue;
  end

  // ---- p1 -> buffer: returned word captured into the output FIFO ----
  audio_nios_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (avm_readdata),
    .rd_en   (xfer),
    .rd_data (smp_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_audio_nios_sample_reader.sv
module tb_audio_nios_sample_reader;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              clk, reset_n, start, stop, loop_en;
  logic [ADDR_W-1:0] base_addr, length, avm_address;
  logic              busy, done, avm_chipselect, avm_read, avm_write, avm_clken;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_readdata, smp_data;
  logic              smp_valid, smp_ready;

  int n_chk = 0;
  int n_err = 0;
  int ready_pct = 100;
  int cyc = 0;
  logic [15:0] seed16;

  logic [ADDR_W-1:0] rd_q[$];
  int                rd_cyc[$];
  logic [DATA_W-1:0] smp_q[$];
  int                acc_cyc[$];
  int                done_q[$];

  audio_nios_sample_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .base_addr(base_addr), .length(length), .loop_en(loop_en),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read(avm_read),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable), .avm_clken(avm_clken),
    .avm_readdata(avm_readdata),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5AC3, ~a ^ seed16};
  endfunction

  // Expected i-th address of a block (looping wraps inside the block).
  function automatic logic [15:0] exp_addr(input logic [15:0] b, input logic [15:0] l, input int i);
    return b + 16'(i % int'(l));
  endfunction

  // Single-port memory with 1-cycle latency; garbage when not read.
  always @(posedge clk) begin
    if (avm_chipselect && avm_read) avm_readdata <= mem_word(avm_address);
    else                            avm_readdata <= $urandom();
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && avm_chipselect && avm_read) begin
      rd_q.push_back(avm_address);
      rd_cyc.push_back(cyc);
    end
    if (reset_n && smp_valid && smp_ready) begin
      smp_q.push_back(smp_data);
      acc_cyc.push_back(cyc);
    end
    if (reset_n && done) done_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (ready_pct >= 100)    smp_ready = 1'b1;
    else if (ready_pct <= 0) smp_ready = 1'b0;
    else                     smp_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic clear_q();
    rd_q.delete(); rd_cyc.delete(); smp_q.delete(); acc_cyc.delete(); done_q.delete();
  endtask

  task automatic start_xfer(input logic [15:0] b, input logic [15:0] l, input logic lp);
    clear_q();
    base_addr = b; length = l; loop_en = lp; start = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (done_q.size() == 0) check_eq("done_timeout", 0, 1);
  endtask

  task automatic verify_stream(input logic [15:0] b, input logic [15:0] l, input int n);
    check_eq("rd_count", rd_q.size(), n);
    check_eq("smp_count", smp_q.size(), n);
    for (int i = 0; i < n && i < rd_q.size(); i++)
      check_eq($sformatf("addr[%0d]", i), rd_q[i], exp_addr(b, l, i));
    for (int i = 0; i < n && i < smp_q.size(); i++)
      check_eq($sformatf("data[%0d]", i), smp_q[i], mem_word(exp_addr(b, l, i)));
    check_eq("done_once", done_q.size(), 1);
    if (done_q.size() > 0 && acc_cyc.size() > 0)
      check_eq("done_timing", done_q[0], acc_cyc[acc_cyc.size()-1] + 1);
    check_eq("busy_after", busy, 0);
  endtask

  task automatic verify_prefix(input logic [15:0] b, input logic [15:0] l);
    check_eq("smp_le_rd", smp_q.size() <= rd_q.size(), 1);
    for (int i = 0; i < rd_q.size(); i++)
      check_eq($sformatf("laddr[%0d]", i), rd_q[i], exp_addr(b, l, i));
    for (int i = 0; i < smp_q.size(); i++)
      check_eq($sformatf("ldata[%0d]", i), smp_q[i], mem_word(exp_addr(b, l, i)));
    check_eq("loop_no_done", done_q.size(), 0);
  endtask

  task automatic stop_and_check();
    int n;
    stop = 1'b1;
    tick();
    check_eq("drain_busy", busy, 1);
    check_eq("drain_valid", smp_valid, 0);
    check_eq("drain_cs", avm_chipselect, 0);
    n = rd_q.size();
    tick();
    check_eq("idle_busy", busy, 0);
    check_eq("stop_no_reads", rd_q.size(), n);
    check_eq("stop_no_done", done_q.size(), 0);
  endtask

  initial begin
    logic [15:0] b, l;
    seed16 = 16'($urandom());
    start = 0; stop = 0; loop_en = 0; base_addr = '0; length = '0; smp_ready = 1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cs", avm_chipselect, 0);
    check_eq("rst_read", avm_read, 0);
    check_eq("rst_addr", avm_address, 0);
    check_eq("rst_valid", smp_valid, 0);
    check_eq("tie_write", avm_write, 0);
    check_eq("tie_be", avm_byteenable, 4'hF);
    check_eq("tie_clken", avm_clken, 1);
    @(posedge clk); @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // Basic block, consumer always ready.
    ready_pct = 100;
    start_xfer(16'h0100, 16'd4, 1'b0);
    wait_done(100);
    verify_stream(16'h0100, 16'd4, 4);
    if (rd_cyc.size() == 4) check_eq("b2b_reads", rd_cyc[3] - rd_cyc[0], 3);

    // Back-pressure: only FIFO_DEPTH reads outstanding; extra start ignored.
    ready_pct = 0;
    start_xfer(16'h2000, 16'd16, 1'b0);
    base_addr = 16'h5000; start = 1'b1;
    tick();
    repeat (18) tick();
    check_eq("bp_reads", rd_q.size(), FIFO_DEPTH);
    check_eq("bp_cs", avm_chipselect, 0);
    check_eq("bp_valid", smp_valid, 1);
    ready_pct = 100;
    wait_done(200);
    verify_stream(16'h2000, 16'd16, 16);

    // Address wrap.
    start_xfer(16'hFFFE, 16'd4, 1'b0);
    wait_done(100);
    verify_stream(16'hFFFE, 16'd4, 4);

    // Random non-looping transfers with random back-pressure.
    for (int t = 0; t < 8; t++) begin
      b = 16'($urandom());
      l = 16'($urandom_range(1, 20));
      ready_pct = $urandom_range(20, 100);
      start_xfer(b, l, 1'b0);
      wait_done(2000);
      ready_pct = 100;
      verify_stream(b, l, int'(l));
    end

    // Looping block with no gap, then stop.
    ready_pct = 100;
    start_xfer(16'h0010, 16'd3, 1'b1);
    repeat (20) tick();
    verify_prefix(16'h0010, 16'd3);
    check_eq("loop_reads", rd_q.size() >= 18, 1);
    if (rd_q.size() > 0)
      check_eq("loop_nogap", rd_cyc[rd_cyc.size()-1] - rd_cyc[0], rd_q.size() - 1);
    stop_and_check();

    // Random looping transfers.
    for (int t = 0; t < 3; t++) begin
      b = 16'($urandom());
      l = 16'($urandom_range(1, 5));
      ready_pct = $urandom_range(30, 100);
      start_xfer(b, l, 1'b1);
      repeat (60) tick();
      verify_prefix(b, l);
      stop_and_check();
    end

    // Zero length, start+stop collision, stop while idle.
    ready_pct = 100;
    start_xfer(16'h0400, 16'd0, 1'b0);
    check_eq("len0_done", done, 1);
    check_eq("len0_busy", busy, 0);
    tick();
    check_eq("len0_done_end", done, 0);
    check_eq("len0_no_read", rd_q.size(), 0);
    clear_q();
    base_addr = 16'h0400; length = 16'd5; start = 1'b1; stop = 1'b1;
    tick();
    check_eq("ss_busy", busy, 0);
    repeat (5) tick();
    check_eq("ss_no_read", rd_q.size(), 0);
    check_eq("ss_no_done", done_q.size(), 0);

    // Reset in the middle of a transfer with words buffered.
    ready_pct = 0;
    start_xfer(16'h3000, 16'd16, 1'b0);
    repeat (4) tick();
    check_eq("pre_rst_valid", smp_valid, 1);
    check_eq("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_cs", avm_chipselect, 0);
    check_eq("mrst_read", avm_read, 0);
    check_eq("mrst_addr", avm_address, 0);
    check_eq("mrst_valid", smp_valid, 0);
    @(posedge clk); @(posedge clk);
    #3 reset_n = 1'b1;
    ready_pct = 100;
    tick();
    check_eq("post_rst_valid", smp_valid, 0);
    b = 16'($urandom());
    start_xfer(b, 16'd7, 1'b0);
    wait_done(200);
    verify_stream(b, 16'd7, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
